// File: rtl/execute_stage_pkg.sv
// Shared pipeline constants: ALU operation codes, forward-select codes and the E/M register layout.
// Decode and the hazard unit import the same definitions.
package execute_stage_pkg;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] FwdReg        = 2'b00;
    localparam logic [1:0] FwdResultW    = 2'b01;
    localparam logic [1:0] FwdAluResultM = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
    } em_t;

    // Select code 11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [31:0] fwd_sel(input logic [1:0]  sel,
                                            input logic [31:0] reg_val,
                                            input logic [31:0] result_w,
                                            input logic [31:0] alu_result_m);
        logic [31:0] val;
        case (sel)
            FwdResultW:    val = result_w;
            FwdAluResultM: val = alu_result_m;
            default:       val = reg_val;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute inputs and execute-to-memory outputs of the execute stage.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface execute_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            RegWriteE;
    logic            ALUSrcE;
    logic            MemWriteE;
    logic            ResultSrcE;
    logic            BranchE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E;
    logic [XLEN-1:0] RD2_E;
    logic [XLEN-1:0] Imm_Ext_E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      RD_E;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] ResultW;

    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            RegWriteM;
    logic            MemWriteM;
    logic            ResultSrcM;
    logic [4:0]      RD_M;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;

    modport master (
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALUResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALUResultM, WriteDataM, PCPlus4M
    );

endinterface

// File: rtl/alu.sv
// Combinational ALU: add, sub, and, or, signed slt; unassigned codes produce 0.
module alu
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      alu_control_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    always_comb begin
        result_o = '0;
        case (alu_control_i)
            AluAdd:  result_o = a_i + b_i;
            AluSub:  result_o = a_i - b_i;
            AluAnd:  result_o = a_i & b_i;
            AluOr:   result_o = a_i | b_i;
            AluSlt:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, beq resolution and the E/M pipeline register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    execute_stage_if.slave bus
);

    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] src_b_e;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] alu_result_e;
    logic            zero_e;
    em_t             em_d;
    em_t             em_q;

    // ALUResultM is the registered value, so a dependent op right behind needs no bubble.
    assign src_a_e      = fwd_sel(bus.ForwardAE, bus.RD1_E, bus.ResultW, em_q.alu_result);
    assign write_data_e = fwd_sel(bus.ForwardBE, bus.RD2_E, bus.ResultW, em_q.alu_result);
    assign src_b_e      = bus.ALUSrcE ? bus.Imm_Ext_E : write_data_e;

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .a_i           (src_a_e),
        .b_i           (src_b_e),
        .alu_control_i (bus.ALUControlE),
        .result_o      (alu_result_e),
        .zero_o        (zero_e)
    );

    assign bus.PCSrcE    = bus.BranchE & zero_e;
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

    always_comb begin
        em_d            = '0;
        em_d.reg_write  = bus.RegWriteE;
        em_d.mem_write  = bus.MemWriteE;
        em_d.result_src = bus.ResultSrcE;
        em_d.rd         = bus.RD_E;
        em_d.alu_result = alu_result_e;
        em_d.write_data = write_data_e;
        em_d.pc_plus4   = bus.PCPlus4E;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            em_q <= '0;
        end else begin
            em_q <= em_d;
        end
    end

    assign bus.RegWriteM  = em_q.reg_write;
    assign bus.MemWriteM  = em_q.mem_write;
    assign bus.ResultSrcM = em_q.result_src;
    assign bus.RD_M       = em_q.rd;
    assign bus.ALUResultM = em_q.alu_result;
    assign bus.WriteDataM = em_q.write_data;
    assign bus.PCPlus4M   = em_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: reset, forwarding, ALU ops, beq, stores and mid-stream reset.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    execute_stage_if #(.XLEN(32)) bus ();

    execute_stage #(
        .XLEN (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic rw, input logic src, input logic mw, input logic rs,
                            input logic br, input logic [2:0] aluc);
        bus.RegWriteE   = rw;
        bus.ALUSrcE     = src;
        bus.MemWriteE   = mw;
        bus.ResultSrcE  = rs;
        bus.BranchE     = br;
        bus.ALUControlE = aluc;
    endtask

    task automatic set_ops(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                           input logic [31:0] pce, input logic [31:0] pcp4, input logic [4:0] rd);
        bus.RD1_E     = rd1;
        bus.RD2_E     = rd2;
        bus.Imm_Ext_E = imm;
        bus.PCE       = pce;
        bus.PCPlus4E  = pcp4;
        bus.RD_E      = rd;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.ForwardAE = FwdReg;
        bus.ForwardBE = FwdReg;
        bus.ResultW   = 32'h55;

        // Reset with nonzero inputs; combinational outputs still follow
        set_ctrl(1, 0, 1, 1, 1, AluSub);
        set_ops(32'd5, 32'd5, 32'd4, 32'h100, 32'h104, 5'd7);
        #1;
        chk("rst_pcsrc", bus.PCSrcE, 1);
        chk("rst_pctarget", bus.PCTargetE, 32'h104);
        tick();
        chk("rst_regwrite", bus.RegWriteM, 0);
        chk("rst_memwrite", bus.MemWriteM, 0);
        chk("rst_resultsrc", bus.ResultSrcM, 0);
        chk("rst_rd", bus.RD_M, 0);
        chk("rst_aluresult", bus.ALUResultM, 0);
        chk("rst_writedata", bus.WriteDataM, 0);
        chk("rst_pcplus4", bus.PCPlus4M, 0);

        // addi x1, x0, 10
        rst = 1'b1;
        set_ctrl(1, 1, 0, 0, 0, AluAdd);
        set_ops(32'd0, 32'd0, 32'd10, 32'h0, 32'h4, 5'd1);
        tick();
        chk("addi_result", bus.ALUResultM, 32'd10);
        chk("addi_rd", bus.RD_M, 5'd1);
        chk("addi_regwrite", bus.RegWriteM, 1);
        chk("addi_memwrite", bus.MemWriteM, 0);
        chk("addi_pcplus4", bus.PCPlus4M, 32'h4);

        // Produce 30 then subtract 10 via ALUResultM forwarding
        set_ops(32'd20, 32'd0, 32'd10, 32'h4, 32'h8, 5'd2);
        tick();
        chk("addi30_result", bus.ALUResultM, 32'd30);
        set_ctrl(1, 0, 0, 0, 0, AluSub);
        set_ops(32'h999, 32'd10, 32'd0, 32'h8, 32'hc, 5'd3);
        bus.ForwardAE = FwdAluResultM;
        tick();
        chk("sub_fwdA_result", bus.ALUResultM, 32'd20);
        chk("sub_fwdA_writedata", bus.WriteDataM, 32'd10);

        // Rebuild 30, then B forwarded from ResultW=5
        bus.ForwardAE = FwdReg;
        set_ctrl(1, 1, 0, 0, 0, AluAdd);
        set_ops(32'd20, 32'd0, 32'd10, 32'hc, 32'h10, 5'd2);
        tick();
        chk("addi30b_result", bus.ALUResultM, 32'd30);
        set_ctrl(1, 0, 0, 0, 0, AluSub);
        set_ops(32'h999, 32'd10, 32'd0, 32'h10, 32'h14, 5'd4);
        bus.ForwardAE = FwdAluResultM;
        bus.ForwardBE = FwdResultW;
        bus.ResultW   = 32'd5;
        tick();
        chk("sub_fwdB_result", bus.ALUResultM, 32'd25);
        chk("sub_fwdB_writedata", bus.WriteDataM, 32'd5);

        // ForwardAE=11 picks RD1; ForwardBE=10 picks ALUResultM (25)
        set_ctrl(1, 0, 0, 1, 0, AluSub);
        set_ops(32'd100, 32'd7, 32'd0, 32'h14, 32'h18, 5'd5);
        bus.ForwardAE = 2'b11;
        bus.ForwardBE = FwdAluResultM;
        tick();
        chk("fwd11_result", bus.ALUResultM, 32'd75);
        chk("fwd11_writedata", bus.WriteDataM, 32'd25);
        chk("fwd11_resultsrc", bus.ResultSrcM, 1);

        // beq taken/not taken, same-cycle outputs
        bus.ForwardAE = FwdReg;
        bus.ForwardBE = FwdReg;
        set_ctrl(0, 0, 0, 0, 1, AluSub);
        set_ops(32'd20, 32'd20, 32'd8, 32'h18, 32'h1c, 5'd0);
        #1;
        chk("beq_taken_pcsrc", bus.PCSrcE, 1);
        chk("beq_pctarget", bus.PCTargetE, 32'h20);
        bus.RD2_E = 32'd19;
        #1;
        chk("beq_nottaken_pcsrc", bus.PCSrcE, 0);
        tick();
        chk("beq_m_result", bus.ALUResultM, 32'd1);
        chk("beq_m_regwrite", bus.RegWriteM, 0);
        chk("beq_m_memwrite", bus.MemWriteM, 0);
        chk("beq_m_pcplus4", bus.PCPlus4M, 32'h1c);

        // slt signed and wrapping add
        set_ctrl(1, 0, 0, 0, 1, AluSlt);
        set_ops(32'hFFFF_FFFF, 32'd1, 32'd0, 32'h20, 32'h24, 5'd6);
        #1;
        chk("slt_zero_low", bus.PCSrcE, 0);
        tick();
        chk("slt_neg_result", bus.ALUResultM, 32'd1);
        bus.ALUControlE = AluAdd;
        #1;
        chk("wrap_zero_pcsrc", bus.PCSrcE, 1);
        tick();
        chk("wrap_result", bus.ALUResultM, 32'd0);
        bus.ALUControlE = AluSlt;
        set_ops(32'd1, 32'hFFFF_FFFF, 32'd0, 32'h28, 32'h2c, 5'd6);
        tick();
        chk("slt_pos_result", bus.ALUResultM, 32'd0);

        // and / or / unassigned codes
        bus.BranchE = 1'b0;
        set_ops(32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'h2c, 32'h30, 5'd8);
        bus.ALUControlE = AluAnd;
        tick();
        chk("and_result", bus.ALUResultM, 32'h00F0_000F);
        bus.ALUControlE = AluOr;
        tick();
        chk("or_result", bus.ALUResultM, 32'hFFF0_0FFF);
        bus.ALUControlE = 3'b111;
        tick();
        chk("op111_result", bus.ALUResultM, 32'd0);
        bus.ALUControlE = 3'b100;
        tick();
        chk("op100_result", bus.ALUResultM, 32'd0);

        // sw
        set_ctrl(0, 1, 1, 0, 0, AluAdd);
        set_ops(32'h100, 32'h1234, 32'd4, 32'h30, 32'h34, 5'd0);
        tick();
        chk("sw_writedata", bus.WriteDataM, 32'h1234);
        chk("sw_memwrite", bus.MemWriteM, 1);
        chk("sw_regwrite", bus.RegWriteM, 0);
        chk("sw_addr", bus.ALUResultM, 32'h104);

        // Mid-stream reset discards, release captures current inputs
        set_ctrl(1, 1, 0, 0, 0, AluAdd);
        set_ops(32'h70, 32'd0, 32'h7, 32'h34, 32'h38, 5'd9);
        rst = 1'b0;
        tick();
        chk("midrst_result", bus.ALUResultM, 32'd0);
        chk("midrst_rd", bus.RD_M, 5'd0);
        rst = 1'b1;
        set_ops(32'd3, 32'd0, 32'd4, 32'h38, 32'h3c, 5'd5);
        tick();
        chk("release_result", bus.ALUResultM, 32'd7);
        chk("release_rd", bus.RD_M, 5'd5);
        chk("release_regwrite", bus.RegWriteM, 1);

        // PC target wraps
        bus.PCE       = 32'hFFFF_FFF0;
        bus.Imm_Ext_E = 32'h20;
        #1;
        chk("pctarget_wrap", bus.PCTargetE, 32'h10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
